// File: rtl/mem_if_pkg.sv
// Shared request encodings, FSM state type and alignment rule for the memory responder.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package mem_if_pkg;

    // Access type codes on W_R_mem (2'b10 is treated as a data read)
    localparam logic [1:0] WR_FETCH = 2'b11;
    localparam logic [1:0] WR_READ  = 2'b00;
    localparam logic [1:0] WR_WRITE = 2'b01;

    // Access size codes on wordsize_mem (2'b11 is treated as a word)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    // Fetches are always full words, regardless of the size field
    function automatic logic is_misaligned(input logic [1:0] w_r,
                                           input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        if (w_r == WR_FETCH) begin
            mis = (addr_lo != 2'b00);
        end else begin
            case (size)
                SZ_BYTE: mis = 1'b0;
                SZ_HALF: mis = addr_lo[0];
                default: mis = (addr_lo != 2'b00);
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: write strobes/replicated data and extended read data for one access.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
    import mem_if_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Write side: enable the addressed lanes and replicate the store data across the word
    always_comb begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Read side: pick the addressed lane and sign- or zero-extend it to 32 bits
    always_comb begin
        byte_sel  = bus_rdata[7:0];
        half_sel  = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        rdata_ext = bus_rdata;
        case (addr_lo)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        case (size)
            SZ_BYTE: rdata_ext = {{24{sign & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_ext = {{16{sign & half_sel[15]}}, half_sel};
            default: rdata_ext = bus_rdata;
        endcase
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Turns one core memory request into one valid/ready bus transaction with alignment checking.
// Latency: mem_valid from N+1 after en_mem; done_mem one cycle after mem_ready is accepted (min N+2).
// Backpressure: holds the bus request stable until mem_ready; optional watchdog aborts to a sticky error.
module mem_bus_responder
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_mem,
    input  logic [1:0]        W_R_mem,
    input  logic [1:0]        wordsize_mem,
    input  logic              sign_mem,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [31:0]       inst,
    output logic              busy_mem,
    output logic              done_mem,
    output logic              aligned_mem,
    output logic              bus_err,
    output logic              mem_valid,
    output logic              mem_instr,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic             WD_EN    = (TIMEOUT_CYCLES > 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic [31:0]       req_wdata_q;
    logic [1:0]        req_wr_q;
    logic [1:0]        req_size_q;
    logic              req_sign_q;
    logic [CNT_W-1:0]  wd_cnt_q;
    logic              aligned_q;
    logic              bus_err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       inst_q;

    logic              req_misaligned;
    logic              bus_ack;
    logic              wd_expire;
    logic [3:0]        lane_wstrb;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;

    assign req_misaligned = is_misaligned(W_R_mem, wordsize_mem, addr[1:0]);
    assign bus_ack        = (state_q == ST_REQ) && mem_ready;
    assign wd_expire      = WD_EN && (state_q == ST_REQ) && !mem_ready && (wd_cnt_q == CNT_LAST);

    // One lane aligner serves both directions, driven from the latched request
    mem_lane_align u_lane (
        .size      (req_size_q),
        .addr_lo   (req_addr_q[1:0]),
        .sign      (req_sign_q),
        .wdata     (req_wdata_q),
        .bus_rdata (mem_rdata),
        .wstrb     (lane_wstrb),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; ERR only leaves through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en_mem) state_d = req_misaligned ? ST_ERR : ST_REQ;
            ST_REQ: begin
                if (mem_ready)      state_d = ST_DONE;
                else if (wd_expire) state_d = ST_ERR;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_ERR;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        mem_valid = (state_q == ST_REQ);
        busy_mem  = (state_q == ST_REQ) || (state_q == ST_DONE);
        done_mem  = (state_q == ST_DONE);
        mem_instr = (state_q == ST_REQ) && (req_wr_q == WR_FETCH);
    end

    // Capture the request when it is accepted in IDLE; held for the whole transaction
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wr_q    <= WR_READ;
            req_size_q  <= SZ_BYTE;
            req_sign_q  <= 1'b0;
        end else if ((state_q == ST_IDLE) && en_mem) begin
            req_addr_q  <= addr;
            req_wdata_q <= wdata;
            req_wr_q    <= W_R_mem;
            req_size_q  <= wordsize_mem;
            req_sign_q  <= sign_mem;
        end
    end

    // Watchdog: counts REQ cycles without an acknowledge
    always_ff @(posedge clk) begin
        if (!reset)                     wd_cnt_q <= '0;
        else if (state_q != ST_REQ)     wd_cnt_q <= '0;
        else if (!mem_ready && WD_EN)   wd_cnt_q <= wd_cnt_q + 1'b1;
    end

    // Sticky error flags: misalignment and bus timeout
    always_ff @(posedge clk) begin
        if (!reset) begin
            aligned_q <= 1'b1;
            bus_err_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && en_mem && req_misaligned) aligned_q <= 1'b0;
            if (wd_expire)                                        bus_err_q <= 1'b1;
        end
    end

    // Completed reads land in rdata, completed fetches in inst; writes leave both alone
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
            inst_q  <= '0;
        end else if (bus_ack) begin
            if (req_wr_q == WR_FETCH)      inst_q  <= mem_rdata;
            else if (req_wr_q != WR_WRITE) rdata_q <= lane_rdata;
        end
    end

    assign mem_addr    = {req_addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata   = lane_wdata;
    assign mem_wstrb   = (req_wr_q == WR_WRITE) ? lane_wstrb : 4'b0000;
    assign rdata       = rdata_q;
    assign inst        = inst_q;
    assign aligned_mem = aligned_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized self-checking bench for mem_bus_responder with a watchdog of 8 cycles.
// Latency: observes each transaction over a fixed window of cycles after en_mem.
// Backpressure: bench plays the memory side, delaying mem_ready by a chosen number of cycles.
module tb_mem_bus_responder;

    localparam int TO  = 8;
    localparam int WIN = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_mem;
    logic [1:0]  W_R_mem;
    logic [1:0]  wordsize_mem;
    logic        sign_mem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] inst;
    logic        busy_mem;
    logic        done_mem;
    logic        aligned_mem;
    logic        bus_err;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_bus_responder #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .en_mem       (en_mem),
        .W_R_mem      (W_R_mem),
        .wordsize_mem (wordsize_mem),
        .sign_mem     (sign_mem),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .inst         (inst),
        .busy_mem     (busy_mem),
        .done_mem     (done_mem),
        .aligned_mem  (aligned_mem),
        .bus_err      (bus_err),
        .mem_valid    (mem_valid),
        .mem_instr    (mem_instr),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: last load result and last fetched instruction
    logic [31:0] exp_rdata;
    logic [31:0] exp_inst;

    // Per-transaction observations, one bit per cycle after en_mem is taken
    logic [63:0] o_valid_m, o_busy_m, o_done_m;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_strb;
    logic        o_instr, o_stable, o_aligned0;

    function automatic logic [63:0] ones(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rb, input logic [1:0] lo,
                                               input logic [1:0] sz, input logic sg);
        longint v;
        if (sz == 2'b00) begin
            v = (rb >> (8 * lo)) % 256;
            if (sg && v >= 128) v = v - 256;
        end else if (sz == 2'b01) begin
            v = (rb >> (8 * lo)) % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end else begin
            v = rb;
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [1:0] lo);
        int s;
        if (sz == 2'b00)      s = 1 << lo;
        else if (sz == 2'b01) s = 3 << lo;
        else                  s = 15;
        return s[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00)      return (wd % 256) * 32'h0101_0101;
        else if (sz == 2'b01) return (wd % 65536) * 32'h0001_0001;
        else                  return wd;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        en_mem = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_rdata = '0;
        exp_inst  = '0;
    endtask

    // Issue one request and play the memory side; records what the DUT showed each cycle
    task automatic txn(input logic [1:0] wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input int dly,
                       input logic [31:0] rb, input logic poke);
        int seen;
        @(negedge clk);
        en_mem = 1'b1; W_R_mem = wr; wordsize_mem = sz; sign_mem = sg; addr = a; wdata = wd;
        @(negedge clk);
        en_mem = 1'b0; W_R_mem = 2'($urandom); wordsize_mem = 2'($urandom);
        sign_mem = 1'($urandom); addr = $urandom; wdata = $urandom;
        o_aligned0 = aligned_mem;
        o_valid_m = '0; o_busy_m = '0; o_done_m = '0;
        o_addr = '0; o_wdata = '0; o_strb = '0; o_instr = 1'b0; o_stable = 1'b1;
        seen = 0;
        for (int c = 0; c < WIN; c++) begin
            o_valid_m[c] = mem_valid;
            o_busy_m[c]  = busy_mem;
            o_done_m[c]  = done_mem;
            if (mem_valid) begin
                if (seen == 0) begin
                    o_addr = mem_addr; o_wdata = mem_wdata; o_strb = mem_wstrb; o_instr = mem_instr;
                end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                             mem_wstrb !== o_strb || mem_instr !== o_instr) begin
                    o_stable = 1'b0;
                end
                seen++;
                mem_ready = (seen == dly + 1);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            mem_rdata = (mem_valid && mem_ready) ? rb : $urandom;
            en_mem = poke && (mem_valid || done_mem);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        en_mem    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy_mem !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_mem); end
        total++; if (done_mem !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_mem); end
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", mem_valid); end
        total++; if (mem_instr !== 1'b0) begin bad++; $display("FAIL rst_instr got=%b want=0", mem_instr); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL rst_bus_err got=%b want=0", bus_err); end
        total++; if (aligned_mem !== 1'b1) begin bad++; $display("FAIL rst_aligned got=%b want=1", aligned_mem); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", mem_wdata); end
        total++; if (mem_wstrb !== 4'h0) begin bad++; $display("FAIL rst_wstrb got=%h want=0", mem_wstrb); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h want=0", inst); end
        reset = 1'b1;
        exp_rdata = '0;
        exp_inst  = '0;
    endtask

    task automatic test_fetch();
        txn(2'b11, 2'b10, 1'b0, 32'h100, 32'h5555_AAAA, 2, 32'hDEAD_BEEF, 1'b0);
        exp_inst = 32'hDEAD_BEEF;
        total++; if (o_instr !== 1'b1) begin bad++; $display("FAIL fetch_instr got=%b want=1", o_instr); end
        total++; if (o_addr !== 32'h100) begin bad++; $display("FAIL fetch_addr got=%h want=100", o_addr); end
        total++; if (o_strb !== 4'h0) begin bad++; $display("FAIL fetch_strb got=%h want=0", o_strb); end
        total++; if (inst !== exp_inst) begin bad++; $display("FAIL fetch_inst got=%h want=%h", inst, exp_inst); end
        total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL fetch_rdata got=%h want=%h", rdata, exp_rdata); end
        total++; if (o_valid_m !== ones(3)) begin bad++; $display("FAIL fetch_valid got=%h want=%h", o_valid_m, ones(3)); end
        total++; if (o_busy_m !== ones(4)) begin bad++; $display("FAIL fetch_busy got=%h want=%h", o_busy_m, ones(4)); end
        total++; if (o_done_m !== (64'd1 << 3)) begin bad++; $display("FAIL fetch_done got=%h want=%h", o_done_m, 64'd1 << 3); end
        total++; if (o_stable !== 1'b1) begin bad++; $display("FAIL fetch_stable got=%b want=1", o_stable); end
    endtask

    task automatic test_reads();
        logic [1:0]  wr, sz, lo;
        logic        sg;
        logic [31:0] a, rb;
        int          dly;
        // Directed cases with hand-computed results
        txn(2'b00, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_0011, 1'b0);
        total++; if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL rd_sbyte got=%h want=ffffff80", rdata); end
        total++; if (o_addr !== 32'h100) begin bad++; $display("FAIL rd_sbyte_addr got=%h want=100", o_addr); end
        total++; if (o_done_m !== (64'd1 << 1)) begin bad++; $display("FAIL rd_sbyte_done got=%h want=2", o_done_m); end
        txn(2'b00, 2'b01, 1'b0, 32'h102, 32'h0, 1, 32'h80FF_0011, 1'b0);
        total++; if (rdata !== 32'h0000_80FF) begin bad++; $display("FAIL rd_uhalf got=%h want=000080ff", rdata); end
        // Randomized aligned reads against the reference model
        for (int i = 0; i < 12; i++) begin
            wr  = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
            sz  = 2'($urandom_range(0, 3));
            lo  = (sz == 2'b00) ? 2'($urandom) : (sz == 2'b01) ? {1'($urandom), 1'b0} : 2'b00;
            a   = ($urandom & 32'hFFFF_FFFC) | {30'd0, lo};
            sg  = 1'($urandom);
            rb  = $urandom;
            dly = $urandom_range(0, 5);
            txn(wr, sz, sg, a, $urandom, dly, rb, 1'b0);
            exp_rdata = model_load(rb, lo, sz, sg);
            total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL rd_rand%0d got=%h want=%h", i, rdata, exp_rdata); end
            total++; if (o_addr !== (a & 32'hFFFF_FFFC)) begin bad++; $display("FAIL rd_addr%0d got=%h want=%h", i, o_addr, a & 32'hFFFF_FFFC); end
            total++; if (o_strb !== 4'h0 || o_instr !== 1'b0) begin bad++; $display("FAIL rd_strb%0d got=%h/%b want=0/0", i, o_strb, o_instr); end
            total++; if (o_done_m !== (64'd1 << (dly + 1))) begin bad++; $display("FAIL rd_done%0d got=%h want=%h", i, o_done_m, 64'd1 << (dly + 1)); end
            total++; if (inst !== exp_inst) begin bad++; $display("FAIL rd_inst%0d got=%h want=%h", i, inst, exp_inst); end
        end
    endtask

    task automatic test_writes();
        logic [1:0]  sz, lo;
        logic [31:0] a, wd, ew;
        int          dly;
        txn(2'b01, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD, 0, $urandom, 1'b0);
        total++; if (o_addr !== 32'h200) begin bad++; $display("FAIL wr_half_addr got=%h want=200", o_addr); end
        total++; if (o_strb !== 4'b1100) begin bad++; $display("FAIL wr_half_strb got=%b want=1100", o_strb); end
        total++; if (o_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL wr_half_data got=%h want=abcdabcd", o_wdata); end
        txn(2'b01, 2'b00, 1'b0, 32'h201, 32'h1234_ABCD, 3, $urandom, 1'b0);
        total++; if (o_strb !== 4'b0010) begin bad++; $display("FAIL wr_byte_strb got=%b want=0010", o_strb); end
        total++; if (o_wdata !== 32'hCDCD_CDCD) begin bad++; $display("FAIL wr_byte_data got=%h want=cdcdcdcd", o_wdata); end
        total++; if (o_stable !== 1'b1) begin bad++; $display("FAIL wr_byte_stable got=%b want=1", o_stable); end
        for (int i = 0; i < 10; i++) begin
            sz  = 2'($urandom_range(0, 3));
            lo  = (sz == 2'b00) ? 2'($urandom) : (sz == 2'b01) ? {1'($urandom), 1'b0} : 2'b00;
            a   = ($urandom & 32'hFFFF_FFFC) | {30'd0, lo};
            wd  = $urandom;
            dly = $urandom_range(0, 5);
            txn(2'b01, sz, 1'($urandom), a, wd, dly, $urandom, 1'b0);
            ew = model_wdata(sz, wd);
            total++; if (o_strb !== model_strb(sz, lo)) begin bad++; $display("FAIL wr_strb%0d got=%b want=%b", i, o_strb, model_strb(sz, lo)); end
            total++; if (o_wdata !== ew) begin bad++; $display("FAIL wr_data%0d got=%h want=%h", i, o_wdata, ew); end
            total++; if (o_valid_m !== ones(dly + 1)) begin bad++; $display("FAIL wr_valid%0d got=%h want=%h", i, o_valid_m, ones(dly + 1)); end
            total++; if (rdata !== exp_rdata || inst !== exp_inst) begin bad++; $display("FAIL wr_keep%0d got=%h/%h want=%h/%h", i, rdata, inst, exp_rdata, exp_inst); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rb;
        // en_mem pulsed throughout REQ and DONE must not start a second transaction
        rb = $urandom;
        txn(2'b00, 2'b10, 1'b0, 32'h340, 32'h0, 4, rb, 1'b1);
        exp_rdata = rb;
        total++; if (o_valid_m !== ones(5)) begin bad++; $display("FAIL b2b_valid got=%h want=%h", o_valid_m, ones(5)); end
        total++; if (o_done_m !== (64'd1 << 5)) begin bad++; $display("FAIL b2b_done got=%h want=%h", o_done_m, 64'd1 << 5); end
        total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL b2b_rdata got=%h want=%h", rdata, exp_rdata); end
        rb = $urandom;
        txn(2'b00, 2'b10, 1'b0, 32'h344, 32'h0, 0, rb, 1'b0);
        exp_rdata = rb;
        total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL b2b_next got=%h want=%h", rdata, exp_rdata); end
    endtask

    task automatic test_misaligned();
        txn(2'b00, 2'b10, 1'b0, 32'h101, 32'h0, 0, $urandom, 1'b0);
        total++; if (o_aligned0 !== 1'b0) begin bad++; $display("FAIL mis_aligned got=%b want=0", o_aligned0); end
        total++; if (o_valid_m !== 64'd0) begin bad++; $display("FAIL mis_valid got=%h want=0", o_valid_m); end
        total++; if (o_busy_m !== 64'd0) begin bad++; $display("FAIL mis_busy got=%h want=0", o_busy_m); end
        total++; if (o_done_m !== 64'd0) begin bad++; $display("FAIL mis_done got=%h want=0", o_done_m); end
        txn(2'b00, 2'b10, 1'b0, 32'h100, 32'h0, 0, $urandom, 1'b0);
        total++; if (o_valid_m !== 64'd0 || o_done_m !== 64'd0) begin bad++; $display("FAIL mis_locked got=%h/%h want=0/0", o_valid_m, o_done_m); end
        total++; if (aligned_mem !== 1'b0) begin bad++; $display("FAIL mis_sticky got=%b want=0", aligned_mem); end
        do_reset();
        total++; if (aligned_mem !== 1'b1) begin bad++; $display("FAIL mis_clear got=%b want=1", aligned_mem); end
        txn(2'b11, 2'b00, 1'b0, 32'h102, 32'h0, 0, $urandom, 1'b0);
        total++; if (o_aligned0 !== 1'b0 || o_valid_m !== 64'd0) begin bad++; $display("FAIL mis_fetch got=%b/%h want=0/0", o_aligned0, o_valid_m); end
        do_reset();
        txn(2'b00, 2'b01, 1'b0, 32'h103, 32'h0, 0, $urandom, 1'b0);
        total++; if (o_aligned0 !== 1'b0 || o_valid_m !== 64'd0) begin bad++; $display("FAIL mis_half got=%b/%h want=0/0", o_aligned0, o_valid_m); end
        do_reset();
    endtask

    task automatic test_timeout();
        logic [31:0] rb;
        txn(2'b00, 2'b10, 1'b0, 32'h300, 32'h0, 99, $urandom, 1'b0);
        total++; if (o_valid_m !== ones(TO)) begin bad++; $display("FAIL to_valid got=%h want=%h", o_valid_m, ones(TO)); end
        total++; if (o_done_m !== 64'd0) begin bad++; $display("FAIL to_done got=%h want=0", o_done_m); end
        total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL to_bus_err got=%b want=1", bus_err); end
        total++; if (aligned_mem !== 1'b1) begin bad++; $display("FAIL to_aligned got=%b want=1", aligned_mem); end
        txn(2'b00, 2'b10, 1'b0, 32'h300, 32'h0, 0, $urandom, 1'b0);
        total++; if (o_valid_m !== 64'd0 || bus_err !== 1'b1) begin bad++; $display("FAIL to_locked got=%h/%b want=0/1", o_valid_m, bus_err); end
        do_reset();
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", bus_err); end
        rb = $urandom;
        txn(2'b00, 2'b10, 1'b0, 32'h300, 32'h0, 1, rb, 1'b0);
        exp_rdata = rb;
        total++; if (rdata !== exp_rdata || o_done_m !== (64'd1 << 2)) begin bad++; $display("FAIL to_fresh got=%h/%h want=%h/%h", rdata, o_done_m, exp_rdata, 64'd1 << 2); end
    endtask

    task automatic test_reset_mid();
        logic late_seen;
        @(negedge clk);
        en_mem = 1'b1; W_R_mem = 2'b00; wordsize_mem = 2'b10; sign_mem = 1'b0; addr = 32'h400;
        @(negedge clk);
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b want=1", mem_valid); end
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        en_mem = 1'b0;
        @(negedge clk);
        total++; if (mem_valid !== 1'b0 || busy_mem !== 1'b0) begin bad++; $display("FAIL mid_reset got=%b/%b want=0/0", mem_valid, busy_mem); end
        reset = 1'b1;
        exp_rdata = '0;
        exp_inst  = '0;
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        late_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done_mem || mem_valid) late_seen = 1'b1;
        end
        mem_ready = 1'b0;
        total++; if (late_seen !== 1'b0) begin bad++; $display("FAIL mid_late_ready got=%b want=0", late_seen); end
        total++; if (rdata !== exp_rdata) begin bad++; $display("FAIL mid_rdata got=%h want=%h", rdata, exp_rdata); end
    endtask

    initial begin
        reset = 1'b0; en_mem = 1'b0; W_R_mem = 2'b00; wordsize_mem = 2'b00; sign_mem = 1'b0;
        addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        exp_rdata = '0; exp_inst = '0;
        test_reset();
        test_fetch();
        test_reads();
        test_writes();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
